// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO for arbitrary depths with thresholds and error pulses
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered one-cycle read.
module sync_fifo_flex #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [WIDTH-1:0]           din,
  input  logic                       ren,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  output logic                       wfull,
  output logic                       rempty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] data_cnt,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_ok;
  logic             rd_ok;

  // Depth need not be a power of two, so the last index wraps explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wfull        = (cnt == CW'(DEPTH));
  assign rempty       = (cnt == '0);
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));
  assign data_cnt     = cnt;

  assign wr_ok = wen && !wfull;
  assign rd_ok = ren && !rempty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[w_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_ptr <= ptr_inc(w_ptr);
      end
      if (rd_ok) begin
        r_ptr <= ptr_inc(r_ptr);
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= wen && wfull;
      underflow <= ren && rempty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout     = mem[r_ptr];
  assign dout_vld = !rempty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd_ok;
      if (rd_ok) begin
        dout <= mem[r_ptr];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - directed bench for sync_fifo_flex (DEPTH=5 and DEPTH=16 instances)
// FWFT-specific scenarios compile only when SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wen5, ren5, vld5, full5, empty5, af5, ae5, ov5, un5;
  logic [7:0] din5, dout5;
  logic [2:0] cnt5;
  logic       wen16, ren16, vld16, full16, empty16, af16, ae16, ov16, un16;
  logic [7:0] din16, dout16;
  logic [4:0] cnt16;

  int checks = 0;
  int failures = 0;

  sync_fifo_flex #(.DEPTH(5), .WIDTH(8)) u5 (
    .clk(clk), .rst(rst), .wen(wen5), .din(din5), .ren(ren5),
    .dout(dout5), .dout_vld(vld5), .wfull(full5), .rempty(empty5),
    .almost_full(af5), .almost_empty(ae5), .data_cnt(cnt5),
    .overflow(ov5), .underflow(un5)
  );

  sync_fifo_flex #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2)) u16 (
    .clk(clk), .rst(rst), .wen(wen16), .din(din16), .ren(ren16),
    .dout(dout16), .dout_vld(vld16), .wfull(full16), .rempty(empty16),
    .almost_full(af16), .almost_empty(ae16), .data_cnt(cnt16),
    .overflow(ov16), .underflow(un16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    wen5 = 1'b0; ren5 = 1'b0; din5 = 8'h00;
    wen16 = 1'b0; ren16 = 1'b0; din16 = 8'h00;
    step();
    step();
    // {dout_vld, rempty, wfull, almost_full, almost_empty, overflow, underflow, data_cnt}
    obs = {vld5, empty5, full5, af5, ae5, ov5, un5, cnt5};
    checks++;
    if (obs !== 10'b0_1_0_0_1_0_0_000) begin
      failures++;
      $display("FAIL reset_flags5 actual=%b expected=%b", obs, 10'b0100100000);
    end
    checks++;
    if ({vld16, empty16, full16, af16, ae16, ov16, un16, cnt16} !== 12'b0_1_0_0_1_0_0_00000) begin
      failures++;
      $display("FAIL reset_flags16 actual=%b expected=%b",
               {vld16, empty16, full16, af16, ae16, ov16, un16, cnt16}, 12'b010010000000);
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (dout5 !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout actual=%h expected=00", dout5);
    end
`endif
    rst = 1'b0;
    step();
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  task automatic test_wrap();
    logic [7:0] exp;
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 5; i++) begin
        wen5 = 1'b1;
        din5 = 8'(8'h11 + i + lap * 32);
        step();
      end
      wen5 = 1'b0;
      checks++;
      if ({full5, cnt5} !== {1'b1, 3'd5}) begin
        failures++;
        $display("FAIL wrap_full lap=%0d actual=%b expected=1101", lap, {full5, cnt5});
      end
      for (int i = 0; i < 5; i++) begin
        ren5 = 1'b1;
        step();
        exp = 8'(8'h11 + i + lap * 32);
        checks++;
        if ({vld5, dout5} !== {1'b1, exp}) begin
          failures++;
          $display("FAIL wrap_read lap=%0d i=%0d actual=%b_%h expected=1_%h", lap, i, vld5, dout5, exp);
        end
      end
      ren5 = 1'b0;
      checks++;
      if ({empty5, cnt5} !== {1'b1, 3'd0}) begin
        failures++;
        $display("FAIL wrap_empty lap=%0d actual=%b expected=1000", lap, {empty5, cnt5});
      end
      step();
      checks++;
      if (vld5 !== 1'b0) begin
        failures++;
        $display("FAIL wrap_vld_drop lap=%0d actual=%b expected=0", lap, vld5);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      wen5 = 1'b1;
      din5 = 8'(8'h31 + i);
      step();
    end
    wen5 = 1'b1; ren5 = 1'b1; din5 = 8'h99;
    step();
    wen5 = 1'b0; ren5 = 1'b0;
    checks++;
    if ({cnt5, ov5, vld5, dout5} !== {3'd4, 1'b1, 1'b1, 8'h31}) begin
      failures++;
      $display("FAIL ovf_both actual=cnt%0d ov%b vld%b %h expected=cnt4 ov1 vld1 31", cnt5, ov5, vld5, dout5);
    end
    step();
    checks++;
    if (ov5 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pulse_len actual=%b expected=0", ov5);
    end
    for (int i = 0; i < 4; i++) begin
      ren5 = 1'b1;
      step();
      checks++;
      if (dout5 !== 8'(8'h32 + i)) begin
        failures++;
        $display("FAIL ovf_drain i=%0d actual=%h expected=%h", i, dout5, 8'(8'h32 + i));
      end
    end
    ren5 = 1'b0;
    checks++;
    if (empty5 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_not_stored actual=%b expected=1", empty5);
    end
  endtask

  task automatic test_underflow();
    ren5 = 1'b1;
    step();
    ren5 = 1'b0;
    checks++;
    if ({un5, vld5, dout5} !== {1'b1, 1'b0, 8'h35}) begin
      failures++;
      $display("FAIL udf_read actual=un%b vld%b %h expected=un1 vld0 35", un5, vld5, dout5);
    end
    step();
    checks++;
    if (un5 !== 1'b0) begin
      failures++;
      $display("FAIL udf_pulse_len actual=%b expected=0", un5);
    end
    wen5 = 1'b1; ren5 = 1'b1; din5 = 8'h4A;
    step();
    wen5 = 1'b0; ren5 = 1'b0;
    checks++;
    if ({cnt5, un5, vld5} !== {3'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL udf_both actual=cnt%0d un%b vld%b expected=cnt1 un1 vld0", cnt5, un5, vld5);
    end
    ren5 = 1'b1;
    step();
    ren5 = 1'b0;
    checks++;
    if ({vld5, dout5} !== {1'b1, 8'h4A}) begin
      failures++;
      $display("FAIL udf_write_kept actual=%b_%h expected=1_4a", vld5, dout5);
    end
  endtask
`endif

  task automatic test_thresholds();
    logic [7:0] exp;
    for (int k = 1; k <= 16; k++) begin
      wen16 = 1'b1;
      din16 = 8'(k);
      step();
      exp = {cnt16, ae16, af16};
      checks++;
      if ({cnt16, ae16, af16, full16} !== {5'(k), k <= 2, k >= 14, k == 16}) begin
        failures++;
        $display("FAIL thr_fill k=%0d actual=%b expected=%b", k, {cnt16, ae16, af16, full16},
                 {5'(k), k <= 2, k >= 14, k == 16});
      end
    end
    wen16 = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      ren16 = 1'b1;
      step();
      checks++;
      if ({cnt16, ae16, af16, empty16} !== {5'(16 - j), (16 - j) <= 2, (16 - j) >= 14, j == 16}) begin
        failures++;
        $display("FAIL thr_drain j=%0d actual=%b expected=%b", j, {cnt16, ae16, af16, empty16},
                 {5'(16 - j), (16 - j) <= 2, (16 - j) >= 14, j == 16});
      end
`ifndef SYNC_FIFO_FWFT_EN
      checks++;
      if (dout16 !== 8'(j)) begin
        failures++;
        $display("FAIL thr_data j=%0d actual=%h expected=%h", j, dout16, 8'(j));
      end
`endif
    end
    ren16 = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wen5 = 1'b1;
      din5 = 8'(8'h61 + i);
      step();
    end
    wen5 = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({vld5, empty5, full5, af5, ae5, ov5, un5, cnt5} !== 10'b0_1_0_0_1_0_0_000) begin
      failures++;
      $display("FAIL rstmid_flags actual=%b expected=0100100000",
               {vld5, empty5, full5, af5, ae5, ov5, un5, cnt5});
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (dout5 !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_dout actual=%h expected=00", dout5);
    end
`endif
    step();
    rst = 1'b0;
    wen5 = 1'b1; din5 = 8'hA5;
    step();
    wen5 = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if ({vld5, dout5} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL rstmid_first actual=%b_%h expected=1_a5", vld5, dout5);
    end
`else
    ren5 = 1'b1;
    step();
    ren5 = 1'b0;
    checks++;
    if ({vld5, dout5} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL rstmid_first actual=%b_%h expected=1_a5", vld5, dout5);
    end
`endif
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wen5 = 1'b1; din5 = 8'h3C;
    step();
    wen5 = 1'b0;
    step();
    checks++;
    if ({vld5, dout5} !== {1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL fwft_show actual=%b_%h expected=1_3c", vld5, dout5);
    end
    ren5 = 1'b1;
    step();
    ren5 = 1'b0;
    checks++;
    if ({vld5, empty5} !== 2'b01) begin
      failures++;
      $display("FAIL fwft_pop actual=%b expected=01", {vld5, empty5});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SYNC_FIFO_FWFT_EN
    test_wrap();
    test_overflow();
    test_underflow();
`endif
    test_thresholds();
    test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO for arbitrary (non-power-of-two) depths, with programmable almost-full/almost-empty thresholds, an occupancy count and overflow/underflow error pulses. It is the drop-in successor for buffering between same-clock producer/consumer pairs. A compile-time option selects first-word-fall-through (FWFT) output.

## Interface

- `DEPTH`, 16: number of entries; any integer ≥ 2, not restricted to powers of two.
- `WIDTH`, 8: data width in bits.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `wen` in 1: write request.
- `din` in WIDTH: write data.
- `ren` in 1: read request; in FWFT mode, pops the head word.
- `dout` out WIDTH: read data.
- `dout_vld` out 1: `dout` holds valid data (meaning depends on mode; see Configuration).
- `wfull` out 1: count == DEPTH.
- `rempty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_LEVEL.
- `almost_empty` out 1: count ≤ AE_LEVEL.
- `data_cnt` out $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- `overflow` out 1: one-cycle pulse; a write was attempted while full.
- `underflow` out 1: one-cycle pulse; a read was attempted while empty.

## Operation

- Accepted write: `wen && !wfull`. Accepted read: `ren && !rempty`. Both decisions use the flags as they stand at the start of the cycle.
- Pointers `w_ptr` and `r_ptr` are $clog2(DEPTH) bits wide. Each wraps explicitly from DEPTH-1 to 0; binary rollover is never relied on.
- Count update per cycle:
  - accepted write only: +1
  - accepted read only: -1
  - both accepted: unchanged
  - neither: unchanged
- Full with `wen && ren`: the read is accepted and the write is rejected. The count becomes DEPTH-1 and `overflow` pulses.
- Empty with `wen && ren`: the write is accepted and the read is rejected. The count becomes 1 and `underflow` pulses.
- A rejected write does not change memory or pointers. A rejected read does not change `dout` or `r_ptr`.
- All flags and `data_cnt` decode only from the registered count register. There is no combinational path from `wen`/`ren` to any flag.
- Memory is not reset; only pointers, count and output registers are.

## Timing

- Reset values (asserted asynchronously, held while `rst` = 1):
  - `dout`=0, `dout_vld`=0, `data_cnt`=0
  - `rempty`=1, `wfull`=0, `almost_empty`=1, `almost_full`=0
  - `overflow`=0, `underflow`=0
- Write at edge N:
  - `data_cnt` and all flags reflect it after edge N.
  - The word is readable from cycle N+1.
- Standard-mode read accepted at edge N: `dout` takes the head word at edge N and `dout_vld`=1 for exactly the following cycle. Otherwise `dout` holds its value and `dout_vld`=0.
- `overflow` and `underflow` are registered: each is high for the one cycle after the offending request edge.
- Reset asserted mid-operation: contents are discarded and all outputs take reset values immediately (asynchronously). The first accepted write after `rst` deasserts goes to entry 0.

## Configuration

- `SYNC_FIFO_FWFT_EN` defined (FWFT mode):
  - `dout` = mem[r_ptr], combinationally, with zero read latency.
  - `dout_vld` = !rempty.
  - `ren` acknowledges and pops the word currently on `dout`; the next word appears in the same cycle as the pop takes effect.
  - `dout` is don't-care while empty.
- `SYNC_FIFO_FWFT_EN` undefined (standard mode): registered one-cycle read latency as described in Timing.
- All other behaviour is identical in both modes.

## Test plan

- DEPTH=5, standard mode, write 0x11..0x15 -> `wfull`=1 and `data_cnt`=5; then read 5 -> `dout` returns 0x11..0x15 in order, each one cycle after its `ren`, and `rempty`=1. Repeat 3 laps to prove wrap at entry 4 -> 0.
- Full (DEPTH=5) with `wen`=`ren`=1 for one cycle -> `data_cnt`=4, `overflow` pulses 1 cycle, `dout`=oldest word, new `din` not stored.
- Empty with `ren`=1 -> `underflow` pulses 1 cycle, `dout_vld`=0, `dout` unchanged. Empty with `wen`=`ren`=1 -> `data_cnt`=1, `underflow` pulses.
- DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: fill one word at a time -> `almost_empty` drops at count 3 and `almost_full` rises at count 14; drain -> mirror transitions.
- Write 3 words, assert `rst` mid-cycle for 1 cycle -> all outputs at reset values immediately. A subsequent write of 0xA5 then read -> `dout`=0xA5.
- `SYNC_FIFO_FWFT_EN` defined: write 0x3C -> next cycle `dout`=0x3C and `dout_vld`=1 with no `ren`. Pulse `ren` -> `dout_vld`=0 and `rempty`=1 the following cycle.
